// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, issues single-outstanding fetches,
// and loads {pc, pc+4, instr} into the IF/ID output register with a one-entry skid.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic [31:0] out_instr,
    output logic        addr_err
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } fetch_out_t;

    state_t          state;
    state_t          state_d;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_pc_d;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_instr_d;
    fetch_out_t      out_q;
    fetch_out_t      out_d;
    logic            out_valid_q;
    logic            out_valid_d;
    logic            addr_err_q;
    logic            addr_err_d;

    assign pc_plus4 = pc + STEP;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; redirect wins over stall and over a response in every state
    always_comb begin
        state_d = state;
        case (state)
            S_REQ: begin
                if (!redirect) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    state_d = (stall && out_valid_q) ? S_HOLD : S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (!redirect && imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        imem_req     = (state == S_REQ) && !redirect;
        imem_addr    = pc;
        pc_d         = pc;
        skid_pc_d    = skid_pc;
        skid_instr_d = skid_instr;
        out_d        = out_q;
        out_valid_d  = out_valid_q && stall;
        addr_err_d   = 1'b0;

        if (redirect) begin
            out_valid_d  = 1'b0;
            skid_pc_d    = '0;
            skid_instr_d = '0;
            pc_d         = {redirect_pc[XLEN-1:2], 2'b00};
            addr_err_d   = |redirect_pc[1:0];
        end else begin
            case (state)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_d = pc_plus4;
                        if (stall && out_valid_q) begin
                            skid_pc_d    = pc;
                            skid_instr_d = imem_rdata;
                        end else begin
                            out_d.pc    = pc;
                            out_d.pc4   = pc_plus4;
                            out_d.instr = imem_rdata;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        out_d.pc     = skid_pc;
                        out_d.pc4    = skid_pc + STEP;
                        out_d.instr  = skid_instr;
                        out_valid_d  = 1'b1;
                        skid_pc_d    = '0;
                        skid_instr_d = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers; a late response after reset is ignored because state restarts in REQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            skid_pc     <= '0;
            skid_instr  <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            pc          <= pc_d;
            skid_pc     <= skid_pc_d;
            skid_instr  <= skid_instr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_q.pc;
    assign out_pc4   = out_q.pc4;
    assign out_instr = out_q.instr;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: latency-programmable memory model, expected-PC scoreboard
// checked by a monitor, and one task per scenario.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_instr;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] req_log[$];

    int          mem_lat = 1;
    bit          mem_en  = 1'b1;
    bit          m_busy  = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_pend  = 32'h0;
    logic        m_req;
    logic [31:0] m_addr;

    pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4),
        .out_instr   (out_instr),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0013_0000;
    endfunction

    // Memory: response sampled mem_lat edges after the accepting edge; mem_en=0 holds it back
    always begin
        @(posedge clk);
        m_req  = imem_req && !rst;
        m_addr = imem_addr;
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (m_busy) begin
            if (m_cnt > 0) m_cnt--;
            if (m_cnt == 0 && mem_en) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(m_pend);
                m_busy      = 1'b0;
            end
        end
        if (m_req) begin
            req_log.push_back(m_addr);
            checks++;
            if (m_busy) begin
                errors++;
                $display("FAIL single_outstanding: request %h while %h still pending", m_addr, m_pend);
            end
            m_pend = m_addr;
            m_cnt  = mem_lat - 1;
            m_busy = 1'b1;
            if (m_cnt == 0 && mem_en) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(m_pend);
                m_busy      = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each newly loaded output, checks hold and addr_err
    logic        p_valid, p_stall, p_redir, p_rst;
    logic [31:0] p_rpc, p_pc, p_pc4, p_instr;
    logic [31:0] e_pc;
    always begin
        @(posedge clk);
        p_valid = out_valid;  p_stall = stall;  p_redir = redirect;  p_rst = rst;
        p_rpc   = redirect_pc; p_pc   = out_pc; p_pc4   = out_pc4;  p_instr = out_instr;
        #1;
        if (!rst && !p_rst) begin
            checks++;
            if (addr_err !== (p_redir && (p_rpc[1:0] != 2'b00))) begin
                errors++;
                $display("FAIL addr_err_pulse: got %b after redirect=%b pc=%h", addr_err, p_redir, p_rpc);
            end
            if (p_redir) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect_flush: out_valid got %b expected 0", out_valid);
                end
            end else if (out_valid === 1'b1 && (!p_stall || !p_valid)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: out_pc %h with empty scoreboard", out_pc);
                end else begin
                    e_pc = exp_q.pop_front();
                    if (out_pc !== e_pc || out_pc4 !== e_pc + 32'd4 || out_instr !== instr_of(e_pc)) begin
                        errors++;
                        $display("FAIL out_payload: got pc=%h pc4=%h instr=%h expected pc=%h pc4=%h instr=%h",
                                 out_pc, out_pc4, out_instr, e_pc, e_pc + 32'd4, instr_of(e_pc));
                    end
                end
            end else if (p_stall && p_valid) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== p_pc || out_pc4 !== p_pc4 || out_instr !== p_instr) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                             out_valid, out_pc, out_instr, p_pc, p_instr);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) cyc();
        checks++;
        if (out_valid !== 1'b0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: out_valid=%b addr_err=%b expected 0 0", out_valid, addr_err);
        end
        checks++;
        if (out_pc !== 32'h0 || out_pc4 !== 32'h0 || out_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got %h %h %h expected zeros", out_pc, out_pc4, out_instr);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            errors++;
            $display("FAIL reset_fetch: req=%b addr=%h expected 1 00003000", imem_req, imem_addr);
        end
    endtask

    task automatic test_fetch_seq();
        int n = 0;
        mem_lat = 1; mem_en = 1'b1;
        req_log.delete();
        exp_q.push_back(32'h0000_3000);
        exp_q.push_back(32'h0000_3004);
        exp_q.push_back(32'h0000_3008);
        rst = 1'b0;
        while (!(out_valid === 1'b1 && out_pc === 32'h0000_3004) && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL fetch_seq_timeout: out_pc %h never reached 00003004", out_pc);
        end
        checks++;
        if (req_log.size() != 2) begin
            errors++;
            $display("FAIL fetch_seq_count: %0d requests expected 2", req_log.size());
        end else if (req_log[0] !== 32'h0000_3000 || req_log[1] !== 32'h0000_3004) begin
            errors++;
            $display("FAIL fetch_seq_order: got %h %h expected 00003000 00003004", req_log[0], req_log[1]);
        end
    endtask

    task automatic test_stall_hold();
        stall = 1'b1;
        cyc();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_wait_req: got %b expected 0", imem_req);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (imem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0000_3004) begin
                errors++;
                $display("FAIL hold_state: req=%b v=%b pc=%h expected 0 1 00003004", imem_req, out_valid, out_pc);
            end
        end
        checks++;
        if (req_log.size() != 3 || req_log[req_log.size()-1] !== 32'h0000_3008) begin
            errors++;
            $display("FAIL hold_req_count: %0d requests expected 3 ending 00003008", req_log.size());
        end
        stall = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_req: got %b expected 0", imem_req);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0000_3008) begin
            errors++;
            $display("FAIL hold_release: v=%b pc=%h expected 1 00003008", out_valid, out_pc);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_300C) begin
            errors++;
            $display("FAIL hold_next_fetch: req=%b addr=%h expected 1 0000300c", imem_req, imem_addr);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_scoreboard: %0d entries left expected 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_wait();
        int n = 0;
        mem_lat = 4;
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_3040;
        exp_q.push_back(32'h0000_3040);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_req_masked: got %b expected 0", imem_req);
        end
        cyc();
        redirect = 1'b0;
        mem_lat = 1;
        while (req_log.size() < 5 && n < 12) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL drop_out_valid: got %b expected 0", out_valid);
            end
            cyc();
            n++;
        end
        checks++;
        if (n != 4 || req_log.size() != 5) begin
            errors++;
            $display("FAIL drop_wait_cycles: got %0d cycles %0d requests expected 4 5", n, req_log.size());
        end else if (req_log[4] !== 32'h0000_3040) begin
            errors++;
            $display("FAIL drop_next_addr: got %h expected 00003040", req_log[4]);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin cyc(); n++; end
        checks++;
        if (out_pc !== 32'h0000_3040 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drop_first_out: pc=%h left=%0d expected 00003040 0", out_pc, exp_q.size());
        end
    endtask

    task automatic test_redirect_rvalid();
        int n = 0;
        mem_lat = 4;
        cyc();
        while (imem_rvalid !== 1'b1 && n < 10) begin cyc(); n++; end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL rr_no_response: waited %0d cycles", n);
        end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3080;
        exp_q.push_back(32'h0000_3080);
        mem_lat = 1;
        cyc();
        redirect = 1'b0; stall = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3080) begin
            errors++;
            $display("FAIL rr_dropped: v=%b req=%b addr=%h expected 0 1 00003080", out_valid, imem_req, imem_addr);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin cyc(); n++; end
        checks++;
        if (out_pc !== 32'h0000_3080 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_first_out: pc=%h left=%0d expected 00003080 0", out_pc, exp_q.size());
        end
    endtask

    task automatic test_addr_err();
        int n = 0;
        redirect = 1'b1; redirect_pc = 32'h0000_3042;
        exp_q.push_back(32'h0000_3040);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL ae_req_masked: got %b expected 0", imem_req);
        end
        cyc();
        redirect = 1'b0;
        #1;
        checks++;
        if (addr_err !== 1'b1 || imem_addr !== 32'h0000_3040 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL ae_pulse: err=%b addr=%h req=%b expected 1 00003040 1", addr_err, imem_addr, imem_req);
        end
        cyc();
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL ae_one_cycle: got %b expected 0", addr_err);
        end
        while (out_valid !== 1'b1 && n < 10) begin cyc(); n++; end
        checks++;
        if (out_pc !== 32'h0000_3040 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ae_first_out: pc=%h left=%0d expected 00003040 0", out_pc, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        mem_lat = 3;
        cyc();
        rst = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'h0000_3000);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_addr !== 32'h0000_3000) begin
            errors++;
            $display("FAIL rm_reset: v=%b pc=%h addr=%h expected 0 0 00003000", out_valid, out_pc, imem_addr);
        end
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 || req_log[req_log.size()-1] !== 32'h0000_3000) begin
            errors++;
            $display("FAIL rm_stale_ignored: v=%b req=%b last=%h expected 0 0 00003000",
                     out_valid, imem_req, req_log[req_log.size()-1]);
        end
        while (out_valid !== 1'b1 && n < 10) begin cyc(); n++; end
        checks++;
        if (out_pc !== 32'h0000_3000 || out_instr !== instr_of(32'h0000_3000) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rm_first_out: pc=%h instr=%h expected 00003000 %h", out_pc, out_instr, instr_of(32'h0000_3000));
        end
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_rvalid();
        test_addr_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
